controle_unidade: RTL and testbench

- Main control decoder for the single-cycle processor.
- Decodes the 3-bit opcode and the instruction LSB into datapath control strobes: ALU op, immediate select, memory read/write, register write, write-back select, branch, jump and halt.
- Decode is combinational, so it is valid in the same cycle as the instruction.
- One sticky "halted" flop freezes the datapath after a halt instruction until reset.

---
 rtl/controle_unidade_pkg.sv | 35 +++
 rtl/controle_decod.sv | 63 ++++++
 rtl/controle_unidade.sv | 74 +++++++
 tb/tb_controle_unidade.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/controle_unidade_pkg.sv
// Shared constants and types for the main control decoder.
package controle_unidade_pkg;

  localparam int unsigned OP_BITS  = 3;
  localparam int unsigned ALU_BITS = 2;

  localparam logic [OP_BITS-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_BITS-1:0] OP_ADDI = 3'b001;
  localparam logic [OP_BITS-1:0] OP_BEQ  = 3'b010;
  localparam logic [OP_BITS-1:0] OP_LW   = 3'b011;
  localparam logic [OP_BITS-1:0] OP_SW   = 3'b100;
  localparam logic [OP_BITS-1:0] OP_JUMP = 3'b101;
  localparam logic [OP_BITS-1:0] OP_SUB  = 3'b110;
  localparam logic [OP_BITS-1:0] OP_RSV  = 3'b111;

  localparam logic [ALU_BITS-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_BITS-1:0] ALU_SUB = 2'b01;

  // Full set of datapath strobes produced by the decoder.
  typedef struct packed {
    logic                halt;
    logic                addi;
    logic                jump;
    logic                beq;
    logic                dado_escrito;
    logic                acessar_memoria;
    logic                imediato;
    logic                escreve_memoria;
    logic                le_memoria;
    logic [ALU_BITS-1:0] operacao_ula;
    logic                escreve_registrador;
    logic                lw;
  } ctrl_t;

endpackage

// File: rtl/controle_decod.sv
// Pure combinational opcode/LSB to control-strobe decoder.
module controle_decod
  import controle_unidade_pkg::*;
(
  input  logic [OP_BITS-1:0] opcode,
  input  logic               bit_menos_sig,
  output ctrl_t              ctrl
);

  // Map each opcode onto its strobe set; unlisted strobes stay 0.
  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_ADD: begin
        if (bit_menos_sig) begin
          ctrl.halt = 1'b1;
        end else begin
          ctrl.escreve_registrador = 1'b1;
          ctrl.operacao_ula        = ALU_ADD;
        end
      end
      OP_ADDI: begin
        ctrl.addi                = 1'b1;
        ctrl.imediato            = 1'b1;
        ctrl.escreve_registrador = 1'b1;
        ctrl.operacao_ula        = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.beq          = 1'b1;
        ctrl.operacao_ula = ALU_SUB;
      end
      OP_LW: begin
        ctrl.lw                  = 1'b1;
        ctrl.le_memoria          = 1'b1;
        ctrl.acessar_memoria     = 1'b1;
        ctrl.imediato            = 1'b1;
        ctrl.dado_escrito        = 1'b1;
        ctrl.escreve_registrador = 1'b1;
        ctrl.operacao_ula        = ALU_ADD;
      end
      OP_SW: begin
        ctrl.escreve_memoria = 1'b1;
        ctrl.acessar_memoria = 1'b1;
        ctrl.imediato        = 1'b1;
        ctrl.operacao_ula    = ALU_ADD;
      end
      OP_JUMP: begin
        ctrl.jump = 1'b1;
      end
      OP_SUB: begin
        ctrl.escreve_registrador = 1'b1;
        ctrl.operacao_ula        = ALU_SUB;
      end
      OP_RSV: begin
        ctrl = '0;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/controle_unidade.sv
// Main control unit: combinational decode plus a sticky halted flop that
// freezes the datapath until reset.
module controle_unidade
  import controle_unidade_pkg::*;
#(
  parameter int unsigned OP_W    = 3,
  parameter int unsigned ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    OPcode,
  input  logic               bit_menos_sig,
  output logic               halt,
  output logic               addi,
  output logic               jump,
  output logic               beq,
  output logic               dadoEscrito,
  output logic               acessarMemoria,
  output logic               imediato,
  output logic               escreveMemoria,
  output logic               leMemoria,
  output logic [ALUOP_W-1:0] operacaoULA,
  output logic               escreveRegistrador,
  output logic               lw
);

  ctrl_t dec;
  ctrl_t out_c;
  logic  halted_d;
  logic  halted_q;

  controle_decod u_decod (
    .opcode        (OPcode),
    .bit_menos_sig (bit_menos_sig),
    .ctrl          (dec)
  );

  // Halted becomes sticky once a halt is decoded.
  always_comb begin
    halted_d = halted_q | dec.halt;
  end

  // Halted flop, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  // Output gating: reset forces everything low (halt included); a halted
  // core shows only halt. rst_n gates combinationally so the drop is immediate.
  always_comb begin
    out_c = dec;
    if (!rst_n) begin
      out_c = '0;
    end else if (halted_q) begin
      out_c      = '0;
      out_c.halt = 1'b1;
    end
  end

  assign halt               = out_c.halt;
  assign addi               = out_c.addi;
  assign jump               = out_c.jump;
  assign beq                = out_c.beq;
  assign dadoEscrito        = out_c.dado_escrito;
  assign acessarMemoria     = out_c.acessar_memoria;
  assign imediato           = out_c.imediato;
  assign escreveMemoria     = out_c.escreve_memoria;
  assign leMemoria          = out_c.le_memoria;
  assign operacaoULA        = out_c.operacao_ula;
  assign escreveRegistrador = out_c.escreve_registrador;
  assign lw                 = out_c.lw;

endmodule

// File: tb/tb_controle_unidade.sv
// Directed bench for controle_unidade with a short random invariant run.
module tb_controle_unidade;

  logic       clk;
  logic       rst_n;
  logic [2:0] OPcode;
  logic       bit_menos_sig;
  logic       halt, addi, jump, beq, dadoEscrito, acessarMemoria, imediato;
  logic       escreveMemoria, leMemoria, escreveRegistrador, lw;
  logic [1:0] operacaoULA;

  int n_cmp;
  int n_fail;

  // Packed view: {halt,addi,jump,beq,dadoEscrito,acessarMemoria,imediato,
  //               escreveMemoria,leMemoria,operacaoULA[1:0],escreveRegistrador,lw}
  localparam logic [12:0] E_ZERO = 13'h0000;
  localparam logic [12:0] E_ADD  = 13'h0002; // escReg
  localparam logic [12:0] E_HALT = 13'h1000; // halt
  localparam logic [12:0] E_ADDI = 13'h0842; // addi, imediato, escReg
  localparam logic [12:0] E_BEQ  = 13'h0204; // beq, ULA=01
  localparam logic [12:0] E_LW   = 13'h01D3; // dado, acessar, imed, leMem, escReg, lw
  localparam logic [12:0] E_SW   = 13'h00E0; // acessar, imed, escMem
  localparam logic [12:0] E_JUMP = 13'h0400; // jump
  localparam logic [12:0] E_SUB  = 13'h0006; // ULA=01, escReg

  logic [12:0] obs;
  assign obs = {halt, addi, jump, beq, dadoEscrito, acessarMemoria, imediato,
                escreveMemoria, leMemoria, operacaoULA, escreveRegistrador, lw};

  controle_unidade #(.OP_W(3), .ALUOP_W(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .OPcode             (OPcode),
    .bit_menos_sig      (bit_menos_sig),
    .halt               (halt),
    .addi               (addi),
    .jump               (jump),
    .beq                (beq),
    .dadoEscrito        (dadoEscrito),
    .acessarMemoria     (acessarMemoria),
    .imediato           (imediato),
    .escreveMemoria     (escreveMemoria),
    .leMemoria          (leMemoria),
    .operacaoULA        (operacaoULA),
    .escreveRegistrador (escreveRegistrador),
    .lw                 (lw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] model(input logic [2:0] op, input logic lsb);
    case (op)
      3'b000:  model = lsb ? E_HALT : E_ADD;
      3'b001:  model = E_ADDI;
      3'b010:  model = E_BEQ;
      3'b011:  model = E_LW;
      3'b100:  model = E_SW;
      3'b101:  model = E_JUMP;
      3'b110:  model = E_SUB;
      default: model = E_ZERO;
    endcase
  endfunction

  task automatic check(input string tag, input logic [12:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %013b expected %013b", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic o, input logic e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic apply(input logic [2:0] op, input logic lsb);
    OPcode        = op;
    bit_menos_sig = lsb;
  endtask

  logic halted_m;
  logic [12:0] exp_r;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    apply(3'b011, 1'b1);

    // Reset forces everything low regardless of opcode, even across an edge.
    #1 check("reset_lw", E_ZERO);
    apply(3'b000, 1'b1);
    @(posedge clk); #1;
    check("reset_halt_op", E_ZERO);

    // Release with add.
    @(negedge clk);
    apply(3'b000, 1'b0);
    rst_n = 1'b1;
    #1 check("release_add", E_ADD);

    // Halt decode then lw, all before a rising edge.
    apply(3'b000, 1'b1);
    #1 check("halt_decode", E_HALT);
    apply(3'b011, 1'b1);
    #1 check("lw_lsb1", E_LW);
    apply(3'b010, 1'b0);
    #1 check("beq", E_BEQ);
    @(posedge clk); #1;
    check("beq_no_halt_latched", E_BEQ);

    // Sweep with both LSB values.
    for (int unsigned o = 1; o < 8; o++) begin
      for (int unsigned b = 0; b < 2; b++) begin
        @(negedge clk);
        apply(3'(o), 1'(b));
        #1 check($sformatf("sweep_op%0d_lsb%0d", o, b), model(3'(o), 1'(b)));
      end
    end
    @(negedge clk);
    apply(3'b000, 1'b0);
    #1 check("add_again", E_ADD);

    // Sticky halt.
    @(negedge clk);
    apply(3'b000, 1'b1);
    @(posedge clk); #1;
    apply(3'b100, 1'b0);
    #1 check("halted_sw", E_HALT);
    @(negedge clk);
    apply(3'b001, 1'b0);
    #1 check("halted_addi", E_HALT);
    @(posedge clk); #1;
    apply(3'b111, 1'b0);
    #1 check("halted_rsv", E_HALT);
    apply(3'b100, 1'b0);
    #1;
    rst_n = 1'b0;
    #1 check("async_reset", E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_sw", E_SW);
    @(posedge clk); #1;
    check("sw_after_edge", E_SW);

    // Random run with a bench-side halted model and invariants.
    halted_m = 1'b0;
    for (int unsigned i = 0; i < 300; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 7) != 0);
      apply(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      if (!rst_n) halted_m = 1'b0;
      #1;
      if (!rst_n)        exp_r = E_ZERO;
      else if (halted_m) exp_r = E_HALT;
      else               exp_r = model(OPcode, bit_menos_sig);
      check("rand_vec", exp_r);
      check_bit("inv_memw_regw", escreveMemoria & escreveRegistrador, 1'b0);
      check_bit("inv_memr_memw", leMemoria & escreveMemoria, 1'b0);
      check_bit("inv_ula_msb", operacaoULA[1], 1'b0);
      @(posedge clk);
      if (rst_n && OPcode == 3'b000 && bit_menos_sig) halted_m = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
